if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline: holds the PC, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register.
- Directly upstream of the hazard detection unit, and consumes its outputs:
  - PC-write enable gates the PC.
  - STALL holds IF/ID.
- The ID-stage branch-resolution flush inserts a bubble into IF/ID and redirects the PC.
- Also keeps saturating stall and flush event counters for the performance report.

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_sat_counter.sv | 26 ++
 rtl/if_stage.sv | 83 ++++++++
 tb/tb_if_stage.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared pipeline constants and the IF/ID bundle type
// Contents:
//   NOP_INSTR : bubble instruction (addi x0,x0,0)
//   PC_STEP   : sequential fetch increment
//   if_id_t   : IF/ID pipeline register bundle {pc, instr, valid}
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/if_stage_sat_counter.sv
// rtl/if_stage_sat_counter.sv - saturating event counter
// Ports:
//   clk   : clock, rising edge
//   clr   : synchronous clear, wins over inc
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, IF/ID register, event counters
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i                 : fetch enable; 0 = PC holds, IF/ID gets bubbles
//   pc_write_i, stall_i     : hazard unit controls (PC enable, IF/ID hold)
//   flush_i, branch_target_i: ID-stage taken branch, squash and redirect
//   imem_addr_o, imem_data_i: instruction memory address / combinational data
//   if_id_pc_o, if_id_instr_o, if_id_valid_o : IF/ID register contents
//   stall_cnt_o, flush_cnt_o: saturating event counters
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pc_write_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      branch_target_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      if_id_pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [31:0] pc;
  if_id_t      if_id;
  logic        stall_evt;
  logic        flush_evt;

  // A flush is only honoured when fetch is enabled and the stage is not stalled;
  // a stalled branch in ID re-resolves on a later cycle.
  assign stall_evt = start_i && stall_i;
  assign flush_evt = start_i && !stall_i && flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc    <= RESET_PC;
      if_id <= IF_ID_BUBBLE;
    end else if (!start_i) begin
      if_id <= IF_ID_BUBBLE;
    end else if (stall_i) begin
      // IF/ID holds; the PC still obeys pc_write_i on its own.
      if (pc_write_i) begin
        pc <= pc + PC_STEP;
      end
    end else if (flush_i) begin
      if_id <= IF_ID_BUBBLE;
      pc    <= branch_target_i & ~32'h3;
    end else begin
      if_id <= '{pc: pc, instr: imem_data_i, valid: 1'b1};
      if (pc_write_i) begin
        pc <= pc + PC_STEP;
      end
    end
  end

  assign imem_addr_o   = pc;
  assign if_id_pc_o    = if_id.pc;
  assign if_id_instr_o = if_id.instr;
  assign if_id_valid_o = if_id.valid;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .clr   (rst_i),
    .inc   (stall_evt),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .clr   (rst_i),
    .inc   (flush_evt),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: default parameters
  logic        rst, start, pc_write, stall, flush;
  logic [31:0] target, imem_addr, imem_data, ipc, iinstr;
  logic        ivalid;
  logic [15:0] scnt, fcnt;

  // second instance: RESET_PC near the top of memory, 2-bit counters
  logic        rst2, start2, pc_write2, stall2, flush2;
  logic [31:0] target2, imem_addr2, imem_data2, ipc2, iinstr2;
  logic        ivalid2;
  logic [1:0]  scnt2, fcnt2;

  // memory model: word at address A reads as A + 0x100
  assign imem_data  = imem_addr + 32'h100;
  assign imem_data2 = imem_addr2 + 32'h100;

  if_stage dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pc_write_i(pc_write),
    .stall_i(stall), .flush_i(flush), .branch_target_i(target),
    .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .if_id_pc_o(ipc), .if_id_instr_o(iinstr), .if_id_valid_o(ivalid),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .start_i(start2), .pc_write_i(pc_write2),
    .stall_i(stall2), .flush_i(flush2), .branch_target_i(target2),
    .imem_addr_o(imem_addr2), .imem_data_i(imem_data2),
    .if_id_pc_o(ipc2), .if_id_instr_o(iinstr2), .if_id_valid_o(ivalid2),
    .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st, pw, sl, fl;
    logic [31:0] tgt;
    logic [31:0] pc, ipc, iin;
    logic        iv;
    logic [15:0] sc, fc;
  } vec_t;

  function automatic vec_t mk(logic st, logic pw, logic sl, logic fl, logic [31:0] tgt,
                              logic [31:0] pc, logic [31:0] ip, logic [31:0] iin,
                              logic iv, logic [15:0] sc, logic [15:0] fc);
    vec_t v;
    v.st = st; v.pw = pw; v.sl = sl; v.fl = fl; v.tgt = tgt;
    v.pc = pc; v.ipc = ip; v.iin = iin; v.iv = iv; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk_main(input string tag, input logic [31:0] pc, input logic [31:0] ip,
                          input logic [31:0] iin, input logic iv,
                          input logic [15:0] sc, input logic [15:0] fc);
    chk({tag, ".pc"},    imem_addr, pc);
    chk({tag, ".ifpc"},  ipc, ip);
    chk({tag, ".instr"}, iinstr, iin);
    chk({tag, ".valid"}, {31'b0, ivalid}, {31'b0, iv});
    chk({tag, ".scnt"},  {16'b0, scnt}, {16'b0, sc});
    chk({tag, ".fcnt"},  {16'b0, fcnt}, {16'b0, fc});
  endtask

  vec_t vecs[19];

  initial begin
    // state expected after the rising edge at which each row's inputs are applied
    vecs[0]  = mk(1,1,0,0, 32'h0,  32'h04, 32'h00, 32'h100, 1, 0, 0);
    vecs[1]  = mk(1,1,0,0, 32'h0,  32'h08, 32'h04, 32'h104, 1, 0, 0);
    vecs[2]  = mk(1,1,0,0, 32'h0,  32'h0C, 32'h08, 32'h108, 1, 0, 0);
    vecs[3]  = mk(1,1,0,0, 32'h0,  32'h10, 32'h0C, 32'h10C, 1, 0, 0);
    vecs[4]  = mk(1,0,1,0, 32'h0,  32'h10, 32'h0C, 32'h10C, 1, 1, 0);
    vecs[5]  = mk(1,0,1,0, 32'h0,  32'h10, 32'h0C, 32'h10C, 1, 2, 0);
    vecs[6]  = mk(1,1,0,0, 32'h0,  32'h14, 32'h10, 32'h110, 1, 2, 0);
    vecs[7]  = mk(1,1,0,0, 32'h0,  32'h18, 32'h14, 32'h114, 1, 2, 0);
    vecs[8]  = mk(1,1,0,0, 32'h0,  32'h1C, 32'h18, 32'h118, 1, 2, 0);
    vecs[9]  = mk(1,1,0,0, 32'h0,  32'h20, 32'h1C, 32'h11C, 1, 2, 0);
    vecs[10] = mk(1,1,0,1, 32'h43, 32'h40, 32'h00, 32'h13,  0, 2, 1);
    vecs[11] = mk(1,1,0,0, 32'h0,  32'h44, 32'h40, 32'h140, 1, 2, 1);
    vecs[12] = mk(1,0,1,1, 32'h99, 32'h44, 32'h40, 32'h140, 1, 3, 1);
    vecs[13] = mk(1,1,0,0, 32'h0,  32'h48, 32'h44, 32'h144, 1, 3, 1);
    vecs[14] = mk(1,1,1,0, 32'h0,  32'h4C, 32'h44, 32'h144, 1, 4, 1);
    vecs[15] = mk(0,1,1,1, 32'h77, 32'h4C, 32'h00, 32'h13,  0, 4, 1);
    vecs[16] = mk(1,0,0,1, 32'h82, 32'h80, 32'h00, 32'h13,  0, 4, 2);
    vecs[17] = mk(1,0,0,0, 32'h0,  32'h80, 32'h80, 32'h180, 1, 4, 2);
    vecs[18] = mk(1,1,0,0, 32'h0,  32'h84, 32'h80, 32'h180, 1, 4, 2);

    rst = 1; start = 0; pc_write = 0; stall = 0; flush = 0; target = 0;
    rst2 = 1; start2 = 0; pc_write2 = 0; stall2 = 0; flush2 = 0; target2 = 0;
    @(posedge clk); #1;
    chk_main("reset", 32'h0, 32'h0, 32'h13, 0, 0, 0);
    chk("reset2.pc", imem_addr2, 32'hFFFF_FFFC);
    rst = 0; rst2 = 0;

    for (int i = 0; i < 19; i++) begin
      start = vecs[i].st; pc_write = vecs[i].pw; stall = vecs[i].sl;
      flush = vecs[i].fl; target = vecs[i].tgt;
      @(posedge clk); #1;
      chk_main($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ipc, vecs[i].iin,
               vecs[i].iv, vecs[i].sc, vecs[i].fc);
    end

    // reset asserted mid-stall: pending stall is discarded, all state returns to reset
    start = 1; pc_write = 1; stall = 1; flush = 1; target = 32'h200; rst = 1;
    @(posedge clk); #1;
    chk_main("rst_mid_stall", 32'h0, 32'h0, 32'h13, 0, 0, 0);
    rst = 0; stall = 0; flush = 0;
    @(posedge clk); #1;
    chk_main("after_rst", 32'h4, 32'h0, 32'h100, 1, 0, 0);

    // PC wrap: 0xFFFF_FFFC + 4 -> 0
    start2 = 1; pc_write2 = 1;
    @(posedge clk); #1;
    chk("wrap.pc", imem_addr2, 32'h0);
    chk("wrap.ifpc", ipc2, 32'hFFFF_FFFC);
    chk("wrap.instr", iinstr2, 32'h0000_00FC);
    chk("wrap.valid", {31'b0, ivalid2}, 32'h1);

    // 2-bit stall counter saturates at 3
    pc_write2 = 0; stall2 = 1;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] exp_cnt;
      exp_cnt = (k < 3) ? 2'(k + 1) : 2'd3;
      @(posedge clk); #1;
      chk($sformatf("sat%0d", k), {30'b0, scnt2}, {30'b0, exp_cnt});
      chk($sformatf("sat%0d.pc", k), imem_addr2, 32'h0);
    end

    // reset during stall on the second instance
    rst2 = 1;
    @(posedge clk); #1;
    chk("rst2.pc", imem_addr2, 32'hFFFF_FFFC);
    chk("rst2.scnt", {30'b0, scnt2}, 32'h0);
    chk("rst2.valid", {31'b0, ivalid2}, 32'h0);
    chk("rst2.instr", iinstr2, 32'h13);
    rst2 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
